uart_tx_arb: RTL and testbench

//  Round-robin arbiter sharing one uart_tx Avalon MM slave port between NRQ Avalon MM masters.
//  It sits between the CPU, debug and other masters and the uart_tx instance.

---
 rtl/uart_tx_arb.sv | 137 +++++++++++++
 tb/tb_uart_tx_arb.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx Avalon-MM slave port between NRQ masters.
// A grant is registered and held for a whole transfer; a locked master keeps it for up to LOCK_MAX transfers.
module uart_tx_arb #(
    parameter int unsigned NRQ      = 2,
    parameter int unsigned AAW      = 1,
    parameter int unsigned ADW      = 32,
    parameter int unsigned ABW      = ADW / 8,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRQ-1:0]       m_read,
    input  logic [NRQ-1:0]       m_write,
    input  logic [NRQ-1:0]       m_lock,
    input  logic [NRQ*AAW-1:0]   m_address,
    input  logic [NRQ*ABW-1:0]   m_byteenable,
    input  logic [NRQ*ADW-1:0]   m_writedata,
    output logic [ADW-1:0]       m_readdata,
    output logic [NRQ-1:0]       m_waitrequest,
    output logic                 s_read,
    output logic                 s_write,
    output logic [AAW-1:0]       s_address,
    output logic [ABW-1:0]       s_byteenable,
    output logic [ADW-1:0]       s_writedata,
    input  logic [ADW-1:0]       s_readdata,
    input  logic                 s_waitrequest
);

    localparam int unsigned GW = (NRQ > 1) ? $clog2(NRQ) : 1;
    localparam int unsigned CW = 8;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_n;
    logic [GW-1:0]   gnt, gnt_n;
    logic [GW-1:0]   ptr, ptr_n;
    logic [CW-1:0]   lcnt, lcnt_n;

    logic [NRQ-1:0]  req;
    logic            req_g;
    logic            lock_g;
    logic            xfer;
    logic [GW-1:0]   pick;
    logic            found;
    logic [GW-1:0]   gnt_inc;
    int unsigned     idx;

    assign req        = m_read | m_write;
    assign req_g      = req[gnt];
    assign lock_g     = m_lock[gnt];
    assign xfer       = (s_read | s_write) & ~s_waitrequest;
    assign gnt_inc    = (gnt == GW'(NRQ - 1)) ? '0 : gnt + GW'(1);
    assign m_readdata = s_readdata;

    // First requester at or after ptr, searching circularly.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NRQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NRQ) idx = idx - NRQ;
            if (!found && req[GW'(idx)]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= '0;
            lcnt  <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            ptr   <= ptr_n;
            lcnt  <= lcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        ptr_n   = ptr;
        lcnt_n  = lcnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    gnt_n   = pick;
                    lcnt_n  = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    // A locked tenure ends after its LOCK_MAX-th transfer regardless of lock.
                    if (lock_g && ((9'(lcnt) + 9'd1) < 9'(LOCK_MAX))) begin
                        lcnt_n = lcnt + CW'(1);
                    end else begin
                        state_n = IDLE;
                        ptr_n   = gnt_inc;
                    end
                end else if (!req_g && !lock_g) begin
                    state_n = IDLE;
                    ptr_n   = gnt_inc;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Slave side muxed from the registered grant; only the granted master sees s_waitrequest.
    always_comb begin
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_address     = '0;
        s_byteenable  = '0;
        s_writedata   = '0;
        m_waitrequest = '1;
        if (state == GRANT) begin
            for (int unsigned i = 0; i < NRQ; i++) begin
                if (gnt == GW'(i)) begin
                    s_read           = m_read[i];
                    s_write          = m_write[i];
                    s_address        = m_address[i*AAW +: AAW];
                    s_byteenable     = m_byteenable[i*ABW +: ABW];
                    s_writedata      = m_writedata[i*ADW +: ADW];
                    m_waitrequest[i] = req[i] ? s_waitrequest : 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with NRQ=3, LOCK_MAX=4; the uart_tx slave is driven by hand.
module tb_uart_tx_arb;

    localparam int unsigned NRQ = 3;
    localparam int unsigned AAW = 1;
    localparam int unsigned ADW = 32;
    localparam int unsigned ABW = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRQ-1:0]       m_read, m_write, m_lock;
    logic [NRQ*AAW-1:0]   m_address;
    logic [NRQ*ABW-1:0]   m_byteenable;
    logic [NRQ*ADW-1:0]   m_writedata;
    logic [ADW-1:0]       m_readdata;
    logic [NRQ-1:0]       m_waitrequest;
    logic                 s_read, s_write;
    logic [AAW-1:0]       s_address;
    logic [ABW-1:0]       s_byteenable;
    logic [ADW-1:0]       s_writedata;
    logic [ADW-1:0]       s_readdata;
    logic                 s_waitrequest;

    int checks = 0;
    int errors = 0;

    uart_tx_arb #(.NRQ(NRQ), .AAW(AAW), .ADW(ADW), .ABW(ABW), .LOCK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .m_read(m_read), .m_write(m_write), .m_lock(m_lock),
        .m_address(m_address), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  rd, wr, lk;
        logic        sw;
        logic [31:0] rdata;
        logic        e_srd, e_swr;
        logic [31:0] e_wd;
        logic [2:0]  e_mw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [2:0] rd, input logic [2:0] wr,
                                input logic [2:0] lk, input logic sw, input logic [31:0] rdata,
                                input logic e_srd, input logic e_swr, input logic [31:0] e_wd,
                                input logic [2:0] e_mw);
        vec_t v;
        v.rst = r; v.rd = rd; v.wr = wr; v.lk = lk; v.sw = sw; v.rdata = rdata;
        v.e_srd = e_srd; v.e_swr = e_swr; v.e_wd = e_wd; v.e_mw = e_mw;
        return v;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Fixed per-master payloads: data 'A','B','C', address 0/1/0, byteenable one-hot.
        m_writedata  = {32'h43, 32'h42, 32'h41};
        m_address    = 3'b010;
        m_byteenable = {4'h4, 4'h2, 4'h1};

        // rst rd wr lk sw rdata | srd swr wd mw
        // reset and single write from m0
        vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b001, 3'b000, 1, 32'h0,  0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b001, 3'b000, 1, 32'h0,  0, 1, 32'h41, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b001, 3'b000, 0, 32'h0,  0, 1, 32'h41, 3'b110));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        // all three request together: order 1,2,0 from ptr=1
        vecs.push_back(mk(0, 3'b000, 3'b111, 3'b000, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b111, 3'b000, 0, 32'h0,  0, 1, 32'h42, 3'b101));
        vecs.push_back(mk(0, 3'b000, 3'b111, 3'b000, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b111, 3'b000, 0, 32'h0,  0, 1, 32'h43, 3'b011));
        vecs.push_back(mk(0, 3'b000, 3'b111, 3'b000, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b111, 3'b000, 0, 32'h0,  0, 1, 32'h41, 3'b110));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        // m1 locked pair with no gap, m2 waiting; locked idle then release
        vecs.push_back(mk(0, 3'b000, 3'b110, 3'b010, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b110, 3'b010, 0, 32'h0,  0, 1, 32'h42, 3'b101));
        vecs.push_back(mk(0, 3'b000, 3'b110, 3'b010, 0, 32'h0,  0, 1, 32'h42, 3'b101));
        vecs.push_back(mk(0, 3'b000, 3'b100, 3'b010, 0, 32'h0,  0, 0, 32'h42, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b100, 3'b000, 0, 32'h0,  0, 0, 32'h42, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b100, 3'b000, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b100, 3'b000, 0, 32'h0,  0, 1, 32'h43, 3'b011));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        // m0 locked: forced release after 4 transfers, m1 served, m0 resumes
        vecs.push_back(mk(0, 3'b000, 3'b011, 3'b001, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b011, 3'b001, 0, 32'h0,  0, 1, 32'h41, 3'b110));
        vecs.push_back(mk(0, 3'b000, 3'b011, 3'b001, 0, 32'h0,  0, 1, 32'h41, 3'b110));
        vecs.push_back(mk(0, 3'b000, 3'b011, 3'b001, 0, 32'h0,  0, 1, 32'h41, 3'b110));
        vecs.push_back(mk(0, 3'b000, 3'b011, 3'b001, 0, 32'h0,  0, 1, 32'h41, 3'b110));
        vecs.push_back(mk(0, 3'b000, 3'b011, 3'b001, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b011, 3'b001, 0, 32'h0,  0, 1, 32'h42, 3'b101));
        vecs.push_back(mk(0, 3'b000, 3'b001, 3'b001, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b001, 3'b001, 0, 32'h0,  0, 1, 32'h41, 3'b110));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 32'h0,  0, 0, 32'h41, 3'b111));
        // reset during a stalled m2 write, then simultaneous requests grant m0
        vecs.push_back(mk(0, 3'b000, 3'b100, 3'b000, 1, 32'h0,  0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b100, 3'b000, 1, 32'h0,  0, 1, 32'h43, 3'b111));
        vecs.push_back(mk(1, 3'b000, 3'b100, 3'b000, 1, 32'h0,  0, 1, 32'h43, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b111, 3'b000, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b111, 3'b000, 0, 32'h0,  0, 1, 32'h41, 3'b110));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        // m2 read with one wait state; read data passes straight through
        vecs.push_back(mk(0, 3'b100, 3'b000, 3'b000, 1, 32'hDEAD, 0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b100, 3'b000, 3'b000, 1, 32'hDEAD, 1, 0, 32'h43, 3'b111));
        vecs.push_back(mk(0, 3'b100, 3'b000, 3'b000, 0, 32'h5A,   1, 0, 32'h43, 3'b011));
        // lock without request stays idle
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b010, 0, 32'h0,  0, 0, 32'h00, 3'b111));
        vecs.push_back(mk(0, 3'b000, 3'b000, 3'b010, 0, 32'h0,  0, 0, 32'h00, 3'b111));

        rst = 1'b1; m_read = '0; m_write = '0; m_lock = '0;
        s_waitrequest = 1'b1; s_readdata = '0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            rst = vecs[i].rst; m_read = vecs[i].rd; m_write = vecs[i].wr; m_lock = vecs[i].lk;
            s_waitrequest = vecs[i].sw; s_readdata = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("vec%0d {srd,swr,wd,mw,rdata}", i),
                  80'({s_read, s_write, s_writedata, m_waitrequest, m_readdata}),
                  80'({vecs[i].e_srd, vecs[i].e_swr, vecs[i].e_wd, vecs[i].e_mw, vecs[i].rdata}));
            @(posedge clk); #1;
        end

        // m1 read at address 1 against a slave that stalls two granted cycles (ptr=0 here).
        begin
            int  wait_cnt = 0;
            bit  done = 0;
            m_lock = '0; m_read = 3'b010; s_waitrequest = 1'b1; s_readdata = 32'h0;
            for (int c = 0; c < 20 && !done; c++) begin
                @(negedge clk);
                if (s_read) begin
                    if (wait_cnt == 2) begin
                        s_waitrequest = 1'b0; s_readdata = 32'h77;
                        #1;
                        check("m1 read addr/be", 80'({s_address, s_byteenable}), 80'({1'b1, 4'h2}));
                        check("m1 read mw/rdata", 80'({m_waitrequest, m_readdata}),
                              80'({3'b101, 32'h77}));
                        done = 1;
                    end else begin
                        check("m1 stalled mw", 80'(m_waitrequest), 80'(3'b111));
                        wait_cnt++;
                    end
                end
                @(posedge clk); #1;
            end
            if (!done) check("m1 read timeout", 80'(0), 80'(1));
            m_read = '0; s_waitrequest = 1'b0;
            @(negedge clk);
            check("after m1 read idle", 80'({s_read, s_write, m_waitrequest}), 80'({2'b00, 3'b111}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
